// File: rtl/phase_timer.sv
// Three-digit BCD countdown timer with IDLE/HOLD/COUNT/DONE control and
// registered glyph outputs for a three-digit display.
module phase_timer #(
    parameter logic [5:0] BLANK_CODE = 6'd55
) (
    input  logic        cp,
    input  logic        reset,
    input  logic        tick,
    input  logic        load,
    input  logic [11:0] load_bcd,
    input  logic        run,
    input  logic        clear,
    output logic [5:0]  inLeft,
    output logic [5:0]  inMiddle,
    output logic [5:0]  inRight,
    output logic        busy,
    output logic        done,
    output logic [1:0]  tstate
);

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned GLYPH_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [DIGIT_W-1:0]   hund_q, hund_d;
    logic [DIGIT_W-1:0]   tens_q, tens_d;
    logic [DIGIT_W-1:0]   ones_q, ones_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [GLYPH_W-1:0]   left_q, left_d;
    logic [GLYPH_W-1:0]   mid_q, mid_d;
    logic [GLYPH_W-1:0]   right_q, right_d;

    logic [DIGIT_W-1:0]   ld_hund, ld_tens, ld_ones;
    logic                 cnt_zero, cnt_one;

    function automatic logic [DIGIT_W-1:0] clamp9(input logic [DIGIT_W-1:0] d);
        return (d > DIGIT_W'(9)) ? DIGIT_W'(9) : d;
    endfunction

    assign ld_hund  = clamp9(load_bcd[11:8]);
    assign ld_tens  = clamp9(load_bcd[7:4]);
    assign ld_ones  = clamp9(load_bcd[3:0]);
    assign cnt_zero = (hund_q == '0) && (tens_q == '0) && (ones_q == '0);
    assign cnt_one  = (hund_q == '0) && (tens_q == '0) && (ones_q == DIGIT_W'(1));

    // Next state and count: clear > load > tick decrement > run transitions.
    always_comb begin
        state_d = state_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        done_d  = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            hund_d  = '0;
            tens_d  = '0;
            ones_d  = '0;
        end else if (load) begin
            hund_d  = ld_hund;
            tens_d  = ld_tens;
            ones_d  = ld_ones;
            state_d = ({ld_hund, ld_tens, ld_ones} != '0) ? ST_HOLD : ST_IDLE;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (run) state_d = ST_COUNT;
                end
                ST_COUNT: begin
                    if (!run) begin
                        state_d = ST_HOLD;
                    end else if (tick && !cnt_zero) begin
                        // BCD borrow chain; count is never zero here so hund cannot underflow
                        if (ones_q != '0) begin
                            ones_d = ones_q - DIGIT_W'(1);
                        end else begin
                            ones_d = DIGIT_W'(9);
                            if (tens_q != '0) begin
                                tens_d = tens_q - DIGIT_W'(1);
                            end else begin
                                tens_d = DIGIT_W'(9);
                                hund_d = hund_q - DIGIT_W'(1);
                            end
                        end
                        if (cnt_one) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_d = (state_d == ST_COUNT);

    // Glyphs follow the registered count/state, hence one cycle behind them.
    always_comb begin
        left_d  = BLANK_CODE;
        mid_d   = BLANK_CODE;
        right_d = BLANK_CODE;
        if (state_q != ST_IDLE) begin
            right_d = GLYPH_W'(ones_q);
            if (hund_q != '0 || tens_q != '0) mid_d = GLYPH_W'(tens_q);
            if (hund_q != '0) left_d = GLYPH_W'(hund_q);
        end
    end

    always_ff @(posedge cp or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hund_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            left_q  <= BLANK_CODE;
            mid_q   <= BLANK_CODE;
            right_q <= BLANK_CODE;
        end else begin
            state_q <= state_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            left_q  <= left_d;
            mid_q   <= mid_d;
            right_q <= right_d;
        end
    end

    assign inLeft   = left_q;
    assign inMiddle = mid_q;
    assign inRight  = right_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign tstate   = state_q;

endmodule

// File: tb/tb_phase_timer.sv
// Randomized and directed bench for phase_timer against an integer-valued
// behavioural model of the countdown (seconds as a plain number 0..999).
module tb_phase_timer;

    localparam int BLANK = 55;

    logic        cp;
    logic        reset;
    logic        tick;
    logic        load;
    logic [11:0] load_bcd;
    logic        run;
    logic        clear;
    logic [5:0]  inLeft, inMiddle, inRight;
    logic        busy, done;
    logic [1:0]  tstate;

    int n_checks = 0;
    int n_errors = 0;

    // model: 0=IDLE 1=HOLD 2=COUNT 3=DONE
    int m_st, m_cnt, m_done, m_busy;
    int e_l, e_m, e_r;

    phase_timer #(.BLANK_CODE(6'd55)) dut (
        .cp(cp), .reset(reset), .tick(tick), .load(load), .load_bcd(load_bcd),
        .run(run), .clear(clear), .inLeft(inLeft), .inMiddle(inMiddle),
        .inRight(inRight), .busy(busy), .done(done), .tstate(tstate)
    );

    initial cp = 1'b0;
    always #5 cp = ~cp;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int bcd_val(input logic [11:0] b);
        int h, t, o;
        h = (int'(b[11:8]) > 9) ? 9 : int'(b[11:8]);
        t = (int'(b[7:4])  > 9) ? 9 : int'(b[7:4]);
        o = (int'(b[3:0])  > 9) ? 9 : int'(b[3:0]);
        return h * 100 + t * 10 + o;
    endfunction

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_done = 0; m_busy = 0;
        e_l = BLANK; e_m = BLANK; e_r = BLANK;
    endtask

    task automatic model_step(input logic ld, input logic [11:0] bcd,
                              input logic rn, input logic tk, input logic clr);
        e_l = (m_st == 0 || m_cnt / 100 == 0) ? BLANK : m_cnt / 100;
        e_m = (m_st == 0 || m_cnt / 10 == 0) ? BLANK : (m_cnt / 10) % 10;
        e_r = (m_st == 0) ? BLANK : m_cnt % 10;
        m_done = 0;
        if (clr) begin
            m_cnt = 0; m_st = 0;
        end else if (ld) begin
            m_cnt = bcd_val(bcd);
            m_st  = (m_cnt != 0) ? 1 : 0;
        end else if (m_st == 1) begin
            if (rn) m_st = 2;
        end else if (m_st == 2) begin
            if (!rn) m_st = 1;
            else if (tk && m_cnt > 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_st = 3; m_done = 1;
                end
            end
        end
        m_busy = (m_st == 2) ? 1 : 0;
    endtask

    task automatic compare_all();
        check("tstate", int'(tstate), m_st);
        check("busy", int'(busy), m_busy);
        check("done", int'(done), m_done);
        check("inLeft", int'(inLeft), e_l);
        check("inMiddle", int'(inMiddle), e_m);
        check("inRight", int'(inRight), e_r);
    endtask

    // Called just after a rising edge; inputs held for one full cycle.
    task automatic step(input logic ld, input logic [11:0] bcd,
                        input logic rn, input logic tk, input logic clr);
        load = ld; load_bcd = bcd; run = rn; tick = tk; clear = clr;
        @(posedge cp);
        model_step(ld, bcd, rn, tk, clr);
        #1;
        compare_all();
    endtask

    // Reset asserted between edges must act without waiting for cp.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge cp);
        #1;
        compare_all();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; load = 1'b0; load_bcd = '0; run = 1'b0; clear = 1'b0;
        model_reset();
        #12;
        compare_all();
        @(posedge cp);
        #1;
        reset = 1'b0;

        // count 012 down to done
        step(1'b1, 12'h012, 1'b0, 1'b0, 1'b0);
        step(1'b0, 12'h000, 1'b1, 1'b1, 1'b0);
        step(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        check("glyph_012_mid", int'(inMiddle), 1);
        check("glyph_012_right", int'(inRight), 2);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 12'h000, 1'b1, 1'b1, 1'b0);
            if (i < 11) step(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        end
        check("done_after_12", int'(done), 1);
        check("tstate_done", int'(tstate), 3);
        step(1'b0, 12'h000, 1'b1, 1'b1, 1'b0);
        check("done_one_cycle", int'(done), 0);
        check("glyph_zero_right", int'(inRight), 0);
        step(1'b0, 12'h000, 1'b1, 1'b1, 1'b0);

        // borrow chain 100 -> 099
        step(1'b1, 12'h100, 1'b0, 1'b0, 1'b0);
        step(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        step(1'b0, 12'h000, 1'b1, 1'b1, 1'b0);
        step(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
        check("borrow_left", int'(inLeft), BLANK);
        check("borrow_mid", int'(inMiddle), 9);
        check("borrow_right", int'(inRight), 9);

        // pause: ticks with run low, then resume with coincident tick
        for (int i = 0; i < 3; i++) step(1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
        step(1'b0, 12'h000, 1'b1, 1'b1, 1'b0);
        step(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        check("pause_right", int'(inRight), 9);

        // clamp and zero load
        step(1'b1, 12'hA5F, 1'b0, 1'b0, 1'b0);
        step(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
        check("clamp_left", int'(inLeft), 9);
        check("clamp_right", int'(inRight), 9);
        step(1'b1, 12'h000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 12'h000, 1'b1, 1'b1, 1'b0);

        // priority: clear with load, load on final tick, reset mid-count
        step(1'b1, 12'h321, 1'b0, 1'b0, 1'b1);
        step(1'b1, 12'h001, 1'b0, 1'b0, 1'b0);
        step(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 12'h042, 1'b1, 1'b1, 1'b0);
        step(1'b0, 12'h000, 1'b1, 1'b1, 1'b0);
        step(1'b0, 12'h000, 1'b1, 1'b1, 1'b0);
        do_reset();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic ld, clr, rn, tk;
            logic [11:0] bcd;
            r   = int'($urandom_range(0, 99));
            clr = (r < 2);
            ld  = (r >= 2 && r < 7);
            bcd[11:8] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            bcd[7:4]  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            bcd[3:0]  = 4'($urandom_range(0, 15));
            rn  = ($urandom_range(0, 9) != 0);
            tk  = ($urandom_range(0, 2) == 0);
            step(ld, bcd, rn, tk, clr);
            if (i % 1000 == 500) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/phase_timer.md
PHASE_TIMER -- requirements
Module: phase_timer

Interface
REQ-001 The block SHALL have parameter BLANK_CODE, default 55: the 6-bit glyph code for an unlit digit.
REQ-002 The block SHALL have port cp, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port tick, input, 1 bit: a one-cp-cycle pulse once per second.
REQ-005 The block SHALL have port load, input, 1 bit: a one-cycle pulse that latches load_bcd.
REQ-006 The block SHALL have port load_bcd, input, 12 bits: the seconds to load as three BCD digits, with [11:8] hundreds, [7:4] tens and [3:0] ones.
REQ-007 The block SHALL have port run, input, 1 bit: a level; 1 enables counting and 0 holds the count.
REQ-008 The block SHALL have port clear, input, 1 bit: a one-cycle pulse that returns the block to idle.
REQ-009 The block SHALL have ports inLeft, inMiddle and inRight, outputs, 6 bits each: glyph codes for the hundreds, tens and ones digits.
REQ-010 The block SHALL have port busy, output, 1 bit: high while in COUNT.
REQ-011 The block SHALL have port done, output, 1 bit: a one-cycle pulse when the count reaches 000.
REQ-012 The block SHALL have port tstate, output, 2 bits: the current state encoded IDLE=0, HOLD=1, COUNT=2, DONE=3.

Function
REQ-013 The block SHALL hold remaining time as three 4-bit BCD digit registers (hund, tens, ones), each always in the range 0-9.
REQ-014 On load, each load_bcd digit greater than 9 SHALL be clamped to 9 before latching.
REQ-015 Per cycle, priority SHALL be clear > load > tick decrement > run-driven transitions.
REQ-016 On clear, from any state, the block SHALL set count to 000 and state to IDLE, with no done pulse.
REQ-017 On load, from any state, the block SHALL latch the clamped digits; next state SHALL be HOLD if the value is nonzero and IDLE if it is 000.
REQ-018 In IDLE, the block SHALL ignore run and tick.
REQ-019 In HOLD, when run=1, the next state SHALL be COUNT; a tick in the same cycle SHALL be ignored, so there is no decrement.
REQ-020 In COUNT, when run=0, the next state SHALL be HOLD, and a coincident tick SHALL be ignored.
REQ-021 In COUNT, when run=1 and tick=1, the count SHALL decrement by one in BCD, with a borrow chain: ones 0 becomes 9 and borrows tens; tens 0 becomes 9 and borrows hundreds.
REQ-022 In COUNT, when a decrement takes the count from 001 to 000, the next state SHALL be DONE and done SHALL pulse high for exactly the following cycle.
REQ-023 In DONE, the block SHALL ignore run and tick and stay until load or clear.
REQ-024 The count SHALL never wrap below 000.
REQ-025 busy SHALL be a registered output equal to (state==COUNT), with no extra delay beyond the state register.
REQ-026 Glyph outputs SHALL be registered and reflect the count and state of the previous cycle, i.e. one cycle of latency after a count or state update.
REQ-027 In IDLE, inLeft, inMiddle and inRight SHALL all equal BLANK_CODE.
REQ-028 In HOLD, COUNT and DONE, inRight SHALL equal the ones digit (code = digit value 0-9).
REQ-029 In HOLD, COUNT and DONE, inMiddle SHALL be BLANK_CODE if both hund and tens are 0, and the tens digit otherwise.
REQ-030 In HOLD, COUNT and DONE, inLeft SHALL be BLANK_CODE if hund is 0, and the hund digit otherwise.
REQ-031 A load coinciding with a decrement-to-000 SHALL take priority, with no done pulse and the new value latched.
REQ-032 A clear coinciding with load SHALL take priority: the load is discarded.

Reset
REQ-033 While reset=1, the block SHALL asynchronously force state IDLE, count 000, glyphs BLANK_CODE/BLANK_CODE/BLANK_CODE, busy=0 and done=0.
REQ-034 After reset deasserts, the block SHALL resume on the first rising edge of cp.
REQ-035 Reset asserted mid-COUNT SHALL abandon the count with no done pulse.

Verification
REQ-036 Reset scenario: reset pulse -> glyphs 55/55/55, tstate=0, busy=0, done=0.
REQ-037 Count-to-done scenario: load_bcd=0x012, run=1, 12 ticks -> glyphs go 55/1/2, 55/1/1, 55/1/0, 55/55/9 ... 55/55/0; done is high exactly one cycle after the 12th tick; tstate=3.
REQ-038 Borrow chain scenario: load_bcd=0x100, run=1, 1 tick -> count 099, glyphs 55/9/9.
REQ-039 Pause scenario: in COUNT, drop run to 0 and apply 3 ticks -> count unchanged, tstate=1, busy=0; raise run with a coincident tick -> no decrement in that cycle.
REQ-040 Clamp and zero-load scenario: load_bcd=0xA5F -> count 959; load_bcd=0x000 -> tstate=0, glyphs 55/55/55, no done.
REQ-041 Priority scenario: clear and load in the same cycle -> IDLE; load on the tick that would reach 000 -> new value latched with no done pulse; reset mid-COUNT -> all outputs at reset values immediately, with no done pulse.
